resize_pipe: RTL
================

Name: resize_pipe

Overview:
- Streaming, parametrised successor to the fixed-width add-and-cast path: adds a constant offset to each input word, then resizes the sum to the output width.
- Resize mode is either wrap (size cast, modulo 2^OUT_W) or unsigned saturate.
- Two-stage pipeline with valid/ready handshakes on both sides, plus a per-word overflow indication.
- Sits between a wide producer and a narrow consumer in datapath regression designs.

Parameters:
- IN_W, 7, input data width (>=1)
- OUT_W, 5, output data width (>=1; may be <, = or > IN_W)
- OFFSET, 2, unsigned constant added to every input word, IN_W bits wide
- SAT, 0, 0 = wrap/truncate (size cast), 1 = saturate to 2^OUT_W-1

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input word present
- in_ready  output  1  block accepts input this cycle
- in_data  input  IN_W  unsigned input word
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_data  output  OUT_W  resized result
- out_ovf  output  1  this result's full sum did not fit in OUT_W bits

Behaviour:
- Reset: rst sampled high at a clk edge clears both stage valids.
  - out_valid=0, out_data=0, out_ovf=0; in_ready=1 the cycle after reset.
  - Reset mid-operation discards in-flight words; no partial output.
- Arithmetic:
  - Stage 1 registers sum = in_data + OFFSET, computed at SW = max(IN_W,OUT_W)+1 bits. The carry is never lost.
  - Stage 2 computes ovf = (sum >= 2^OUT_W).
  - SAT=0: out_data = sum[OUT_W-1:0], identical to OUT_W'(sum).
  - SAT=1: out_data = ovf ? all-ones : sum[OUT_W-1:0].
  - OUT_W >= IN_W+1: ovf is constant 0 and out_data is the zero-extended sum.
- Handshake:
  - Transfer occurs on a cycle where valid && ready.
  - advance2 = !out_valid || out_ready; stage 2 loads from stage 1 when advance2.
  - in_ready = !s1_valid || advance2 (combinational from out_ready, no combinational path from in_valid).
  - Stage 1 loads when in_ready. Its valid becomes in_valid.
- Latency and ordering:
  - Latency is 2 cycles when out_ready is held high: a word accepted at edge N appears with out_valid at edge N+2.
  - Throughput is 1 word/cycle. Order is preserved.
- Stall: while out_valid && !out_ready, out_data and out_ovf hold stable. Stage 1 fills, then in_ready drops. No word is lost or duplicated.
- Simultaneous events:
  - Output transfer and new acceptance occur in the same cycle when the pipeline is full and out_ready=1.
  - rst overrides all handshakes.
- Empty pipeline: out_valid=0; out_data and out_ovf hold their last values, don't-care to the consumer.

Optional Feature:
- Macro: RESIZE_PIPE_STATS_EN.
- Defined: add output port ovf_count (16 bits).
  - Increments on each output transfer with out_ovf=1.
  - Saturates at 16'hFFFF; cleared by rst.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Defaults, SAT=0, out_ready=1: in_data=39 -> two cycles later out_data=9, out_ovf=1 (41 mod 32).
- Same with SAT=1: in_data=39 -> out_data=31, out_ovf=1. in_data=20 -> out_data=22, out_ovf=0.
- Backpressure: stream 0..9 with out_ready low for cycles 3-6.
  - in_ready drops after two words are buffered.
  - Outputs are exactly 2..11 in order, with no gaps or duplicates.
  - out_data holds stable while stalled.
- Reset mid-stream: assert rst for 1 cycle with both stages valid -> out_valid=0 next cycle, in_ready=1, and no stale word emerges afterwards.
- Widening, IN_W=4, OUT_W=8, OFFSET=15: in_data=15 -> out_data=30, out_ovf=0.
- RESIZE_PIPE_STATS_EN: 5 overflowing plus 3 non-overflowing transfers -> ovf_count=5. After rst -> ovf_count=0.

Source files
------------

// File: rtl/resize_pipe.sv
// resize_pipe: adds OFFSET to each word, then wraps or saturates it to OUT_W in a 2-stage valid/ready pipeline.
// Define RESIZE_PIPE_STATS_EN to add the saturating ovf_count output.
module resize_pipe #(
    parameter int          IN_W   = 7,
    parameter int          OUT_W  = 5,
    parameter int unsigned OFFSET = 2,
    parameter bit          SAT    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
`ifdef RESIZE_PIPE_STATS_EN
    output logic [15:0]      ovf_count,
`endif
    output logic             out_ovf
);
    localparam int SW = (IN_W > OUT_W ? IN_W : OUT_W) + 1;
    localparam logic [IN_W-1:0] OFF_N = IN_W'(OFFSET);
    logic             s1_valid_q, s1_valid_d;
    logic [SW-1:0]    s1_sum_q, s1_sum_d;
    logic             s2_valid_q, s2_valid_d;
    logic [OUT_W-1:0] s2_data_q, s2_data_d;
    logic             s2_ovf_q, s2_ovf_d;
    logic             advance2, load2, ovf;
    always_comb begin
        advance2   = !s2_valid_q || out_ready;
        in_ready   = !s1_valid_q || advance2;
        s1_valid_d = in_ready ? in_valid : s1_valid_q;
        s1_sum_d   = (in_ready && in_valid) ? SW'(in_data) + SW'(OFF_N) : s1_sum_q;
        ovf        = |s1_sum_q[SW-1:OUT_W];
        load2      = advance2 && s1_valid_q;
        s2_valid_d = advance2 ? s1_valid_q : s2_valid_q;
        s2_ovf_d   = load2 ? ovf : s2_ovf_q;
        s2_data_d  = load2 ? ((SAT && ovf) ? '1 : s1_sum_q[OUT_W-1:0]) : s2_data_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_ovf_q   <= s2_ovf_d;
        end
    end
    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_ovf   = s2_ovf_q;
`ifdef RESIZE_PIPE_STATS_EN
    logic [15:0] ovf_count_q, ovf_count_d;
    always_comb begin
        ovf_count_d = (out_valid && out_ready && out_ovf && ovf_count_q != 16'hFFFF) ? ovf_count_q + 16'd1 : ovf_count_q;
    end
    always_ff @(posedge clk) begin
        if (rst) ovf_count_q <= '0;
        else     ovf_count_q <= ovf_count_d;
    end
    assign ovf_count = ovf_count_q;
`endif
endmodule
